// File: rtl/seg7_scan_driver_if.sv
// Bus between the configuration register block and the 3-digit display scanner.
interface seg7_scan_driver_if;
   logic [11:0] smg_in;
   logic        disp_en;
   logic [6:0]  seg_out;
   logic [2:0]  an_out;
   logic        frame_tick;

   modport master (output smg_in, disp_en, input seg_out, an_out, frame_tick);
   modport slave  (input smg_in, disp_en, output seg_out, an_out, frame_tick);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 3-digit hex seven-segment driver with ghost-blanking gap,
// frame-coherent value snapshot and optional leading-zero suppression.
module seg7_scan_driver #(
   parameter int SCAN_DIV       = 50000,
   parameter int GAP_CYC        = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit BLANK_LZ       = 1'b0
) (
   input logic               clk,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);
   localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]      AN_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
      endcase
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [11:0]      snap_q, snap_d;
   logic             tick_q, tick_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;

   logic             wrap, frame_end, blank;
   logic [3:0]       nib;
   logic [6:0]       pat;
   logic [2:0]       an_act;

   always_comb begin
      wrap      = (cnt_q == CNT_LAST);
      frame_end = wrap && (idx_q == 2'd2);
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      snap_d    = frame_end ? bus.smg_in : snap_q;
      tick_d    = frame_end;

      case (idx_q)
         2'd0:    nib = snap_q[3:0];
         2'd1:    nib = snap_q[7:4];
         default: nib = snap_q[11:8];
      endcase
      pat = hex_decode(nib);

      // Digit0 is never suppressed, so a zero value still shows a single "0".
      blank = !bus.disp_en
            || (BLANK_LZ && (idx_q == 2'd2) && (snap_q[11:8] == 4'h0))
            || (BLANK_LZ && (idx_q == 2'd1) && (snap_q[11:4] == 8'h00));

      an_act = '0;
      if (!blank && (int'(cnt_q) >= GAP_CYC)) an_act = 3'b001 << idx_q;
      an_d  = AN_ACTIVE_LOW ? ~an_act : an_act;
      seg_d = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~pat : pat);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         idx_q  <= 2'd0;
         snap_q <= 12'h000;
         tick_q <= 1'b0;
         seg_q  <= SEG_OFF;
         an_q   <= AN_OFF;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         tick_q <= tick_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.an_out     = an_q;
   assign bus.frame_tick = tick_q;
endmodule
